clint: RTL and testbench

Core-local interrupt/exception sequencer: the master of the CSR file's `clint_*` side port. It detects `ecall`, `ebreak`, `mret` and external interrupt requests, stalls the pipeline, and writes trap state (MEPC, MCAUSE) through the CSR file's clint write port. It then reads MTVEC (on a trap) or MEPC (on `mret`) through the clint read port and issues a redirect to the PC/fetch logic.

---
 rtl/clint_pkg.sv | 22 ++
 rtl/clint.sv | 141 ++++++++++++++
 tb/tb_clint.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/clint_pkg.sv
// Shared constants for the core-local interrupt sequencer: CSR addresses,
// SYSTEM instruction encodings and trap cause codes.
package clint_pkg;

  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_IRQ    = 32'h8000_000B;

  // CSR port addresses are 12 significant bits, zero-extended onto 32-bit buses.
  function automatic logic [31:0] csr_addr(input logic [11:0] a);
    return {20'd0, a};
  endfunction

endpackage

// File: rtl/clint.sv
// Core-local interrupt/exception sequencer: stalls the pipeline, writes MEPC and
// MCAUSE through the CSR side port, then redirects fetch to MTVEC or MEPC.
module clint
  import clint_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic [7:0]  int_flag_i,
  input  logic [31:0] csr_data_i,
  output logic        csr_we_o,
  output logic [31:0] csr_waddr_o,
  output logic [31:0] csr_raddr_o,
  output logic [31:0] csr_data_o,
  output logic        hold_flag_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_MEPC,
    S_WR_MCAUSE,
    S_TRAP_JMP,
    S_MRET_JMP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;

  logic        csr_we_q, csr_we_d;
  logic [31:0] csr_waddr_q, csr_waddr_d;
  logic [31:0] csr_raddr_q, csr_raddr_d;
  logic [31:0] csr_wdata_q, csr_wdata_d;
  logic        int_assert_q, int_assert_d;

  logic        ev_trap, ev_mret;
  logic [31:0] ev_cause;

  // Event decode; exceptions outrank mret, which outranks a pending IRQ.
  always_comb begin
    // NOTE: every signal gets a default before the if-chain so no latch is inferred.
    ev_trap  = 1'b0;
    ev_mret  = 1'b0;
    ev_cause = '0;
    if (inst_i == INST_ECALL) begin
      ev_trap  = 1'b1;
      ev_cause = CAUSE_ECALL;
    end else if (inst_i == INST_EBREAK) begin
      ev_trap  = 1'b1;
      ev_cause = CAUSE_EBREAK;
    end else if (inst_i == INST_MRET) begin
      ev_mret  = 1'b1;
    end else if (|int_flag_i) begin
      ev_trap  = 1'b1;
      ev_cause = CAUSE_IRQ;
    end
  end

  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    unique case (state_q)
      S_IDLE: begin
        if (ev_trap) begin
          cause_d = ev_cause;
          epc_d   = jump_flag_i ? jump_addr_i : inst_addr_i;
          state_d = S_WR_MEPC;
        end else if (ev_mret) begin
          state_d = S_MRET_JMP;
        end
      end
      S_WR_MEPC:   state_d = S_WR_MCAUSE;
      S_WR_MCAUSE: state_d = S_TRAP_JMP;
      S_TRAP_JMP:  state_d = S_IDLE;
      S_MRET_JMP:  state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Outputs are precomputed from the next state so they come straight off flops.
  always_comb begin
    csr_we_d     = (state_d == S_WR_MEPC) || (state_d == S_WR_MCAUSE);
    int_assert_d = (state_d == S_TRAP_JMP) || (state_d == S_MRET_JMP);
    csr_waddr_d  = '0;
    csr_wdata_d  = '0;
    csr_raddr_d  = '0;
    case (state_d)
      S_WR_MEPC: begin
        csr_waddr_d = csr_addr(CSR_MEPC);
        csr_wdata_d = epc_d;
      end
      S_WR_MCAUSE: begin
        csr_waddr_d = csr_addr(CSR_MCAUSE);
        csr_wdata_d = cause_d;
      end
      S_TRAP_JMP: csr_raddr_d = csr_addr(CSR_MTVEC);
      S_MRET_JMP: csr_raddr_d = csr_addr(CSR_MEPC);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and clears every flop, so an abort mid-sequence
    // suppresses all later writes and the redirect from the very next cycle.
    if (rst) begin
      state_q      <= S_IDLE;
      epc_q        <= '0;
      cause_q      <= '0;
      csr_we_q     <= 1'b0;
      csr_waddr_q  <= '0;
      csr_raddr_q  <= '0;
      csr_wdata_q  <= '0;
      int_assert_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q      <= state_d;
      epc_q        <= epc_d;
      cause_q      <= cause_d;
      csr_we_q     <= csr_we_d;
      csr_waddr_q  <= csr_waddr_d;
      csr_raddr_q  <= csr_raddr_d;
      csr_wdata_q  <= csr_wdata_d;
      int_assert_q <= int_assert_d;
    end
  end

  assign csr_we_o     = csr_we_q;
  assign csr_waddr_o  = csr_waddr_q;
  assign csr_raddr_o  = csr_raddr_q;
  assign csr_data_o   = csr_wdata_q;
  assign int_assert_o = int_assert_q;
  assign int_addr_o   = int_assert_q ? csr_data_i : 32'd0;
  assign hold_flag_o  = (state_q != S_IDLE) || ev_trap || ev_mret;

endmodule

// File: tb/tb_clint.sv
// Directed bench for clint: a cycle table for plain trap sequences, then
// hand-written mret, simultaneous-event and mid-sequence reset scenarios.
module tb_clint;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] MTVEC  = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i, inst_addr_i, jump_addr_i, csr_data_i;
  logic        jump_flag_i;
  logic [7:0]  int_flag_i;
  logic        csr_we_o, hold_flag_o, int_assert_o;
  logic [31:0] csr_waddr_o, csr_raddr_o, csr_data_o, int_addr_o;

  int n_checks = 0;
  int n_fails  = 0;

  clint dut (
    .clk          (clk),
    .rst          (rst),
    .inst_i       (inst_i),
    .inst_addr_i  (inst_addr_i),
    .jump_flag_i  (jump_flag_i),
    .jump_addr_i  (jump_addr_i),
    .int_flag_i   (int_flag_i),
    .csr_data_i   (csr_data_i),
    .csr_we_o     (csr_we_o),
    .csr_waddr_o  (csr_waddr_o),
    .csr_raddr_o  (csr_raddr_o),
    .csr_data_o   (csr_data_o),
    .hold_flag_o  (hold_flag_o),
    .int_assert_o (int_assert_o),
    .int_addr_o   (int_addr_o)
  );

  always #5 clk = ~clk;

  // Minimal CSR file: fixed MTVEC, writable MEPC (bench can preset it).
  logic [31:0] mepc_m = 32'd0;
  logic        preset_en = 1'b0;
  logic [31:0] preset_val = 32'd0;

  always @(posedge clk) begin
    if (preset_en) mepc_m <= preset_val;
    else if (csr_we_o && csr_waddr_o == 32'h341) mepc_m <= csr_data_o;
  end

  always_comb begin
    csr_data_i = 32'd0;
    if (csr_raddr_o == 32'h305) csr_data_i = MTVEC;
    else if (csr_raddr_o == 32'h341) csr_data_i = mepc_m;
  end

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] addr;
    logic        jf;
    logic [31:0] jaddr;
    logic [7:0]  irq;
    logic        e_hold;
    logic        e_we;
    logic [31:0] e_waddr;
    logic [31:0] e_wdata;
    logic [31:0] e_raddr;
    logic        e_assert;
    logic [31:0] e_iaddr;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic hold, input logic we,
                         input logic [31:0] waddr, input logic [31:0] wdata,
                         input logic [31:0] raddr, input logic as,
                         input logic [31:0] iaddr);
    check({name, ".hold"},   {31'd0, hold_flag_o},  {31'd0, hold});
    check({name, ".we"},     {31'd0, csr_we_o},     {31'd0, we});
    check({name, ".waddr"},  csr_waddr_o,           waddr);
    check({name, ".wdata"},  csr_data_o,            wdata);
    check({name, ".raddr"},  csr_raddr_o,           raddr);
    check({name, ".assert"}, {31'd0, int_assert_o}, {31'd0, as});
    check({name, ".iaddr"},  int_addr_o,            iaddr);
  endtask

  // Drive one cycle's inputs just after the edge; return at the falling edge.
  task automatic drive(input logic [31:0] inst, input logic [31:0] addr, input logic jf,
                       input logic [31:0] jaddr, input logic [7:0] irq);
    @(posedge clk);
    #1;
    inst_i      = inst;
    inst_addr_i = addr;
    jump_flag_i = jf;
    jump_addr_i = jaddr;
    int_flag_i  = irq;
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{"ecall_T",   ECALL, 32'h100, 1'b0, 32'h0,   8'h00, 1, 0, 32'h0,   32'h0,   32'h0,   0, 32'h0};
    vecs[1]  = '{"ecall_T1",  NOP,   32'h104, 1'b0, 32'h0,   8'h00, 1, 1, 32'h341, 32'h100, 32'h0,   0, 32'h0};
    vecs[2]  = '{"ecall_T2",  NOP,   32'h104, 1'b0, 32'h0,   8'h00, 1, 1, 32'h342, 32'd11,  32'h0,   0, 32'h0};
    vecs[3]  = '{"ecall_T3",  NOP,   32'h104, 1'b0, 32'h0,   8'h00, 1, 0, 32'h0,   32'h0,   32'h305, 1, MTVEC};
    vecs[4]  = '{"ecall_T4",  NOP,   32'h104, 1'b0, 32'h0,   8'h00, 0, 0, 32'h0,   32'h0,   32'h0,   0, 32'h0};
    vecs[5]  = '{"irq_T",     NOP,   32'h108, 1'b1, 32'h400, 8'h01, 1, 0, 32'h0,   32'h0,   32'h0,   0, 32'h0};
    vecs[6]  = '{"irq_T1",    NOP,   32'h10C, 1'b0, 32'h0,   8'h00, 1, 1, 32'h341, 32'h400, 32'h0,   0, 32'h0};
    vecs[7]  = '{"irq_T2",    NOP,   32'h10C, 1'b0, 32'h0,   8'h00, 1, 1, 32'h342, 32'h8000000B, 32'h0, 0, 32'h0};
    vecs[8]  = '{"irq_T3",    NOP,   32'h10C, 1'b0, 32'h0,   8'h00, 1, 0, 32'h0,   32'h0,   32'h305, 1, MTVEC};
    vecs[9]  = '{"irq_T4",    NOP,   32'h10C, 1'b0, 32'h0,   8'h00, 0, 0, 32'h0,   32'h0,   32'h0,   0, 32'h0};
    vecs[10] = '{"ebreak_T",  EBREAK, 32'h10C, 1'b0, 32'h0,  8'h00, 1, 0, 32'h0,   32'h0,   32'h0,   0, 32'h0};
    vecs[11] = '{"ebreak_T1", NOP,   32'h110, 1'b0, 32'h0,   8'h00, 1, 1, 32'h341, 32'h10C, 32'h0,   0, 32'h0};
    vecs[12] = '{"ebreak_T2", NOP,   32'h110, 1'b0, 32'h0,   8'h00, 1, 1, 32'h342, 32'd3,   32'h0,   0, 32'h0};
    vecs[13] = '{"ebreak_T3", NOP,   32'h110, 1'b0, 32'h0,   8'h00, 1, 0, 32'h0,   32'h0,   32'h305, 1, MTVEC};
    vecs[14] = '{"ebreak_T4", NOP,   32'h110, 1'b0, 32'h0,   8'h00, 0, 0, 32'h0,   32'h0,   32'h0,   0, 32'h0};

    rst = 1'b1;
    inst_i = NOP; inst_addr_i = 32'h0; jump_flag_i = 1'b0; jump_addr_i = 32'h0; int_flag_i = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_out("reset", 0, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].inst, vecs[i].addr, vecs[i].jf, vecs[i].jaddr, vecs[i].irq);
      chk_out(vecs[i].name, vecs[i].e_hold, vecs[i].e_we, vecs[i].e_waddr, vecs[i].e_wdata,
              vecs[i].e_raddr, vecs[i].e_assert, vecs[i].e_iaddr);
    end

    // mret: redirect to stored MEPC, no CSR writes
    @(posedge clk);
    #1 preset_en = 1'b1; preset_val = 32'h104;
    @(posedge clk);
    #1 preset_en = 1'b0;
    drive(MRET, 32'h120, 1'b0, 32'h0, 8'h00);
    chk_out("mret_T",  1, 0, 32'h0, 32'h0, 32'h0,   0, 32'h0);
    drive(NOP,  32'h124, 1'b0, 32'h0, 8'h00);
    chk_out("mret_T1", 1, 0, 32'h0, 32'h0, 32'h341, 1, 32'h104);
    drive(NOP,  32'h124, 1'b0, 32'h0, 8'h00);
    chk_out("mret_T2", 0, 0, 32'h0, 32'h0, 32'h0,   0, 32'h0);

    // ecall with IRQ in the same cycle; held IRQ is taken on return to IDLE
    drive(ECALL, 32'h200, 1'b0, 32'h0, 8'h80);
    chk_out("sim_T",  1, 0, 32'h0,   32'h0,   32'h0,   0, 32'h0);
    drive(NOP,   32'h204, 1'b0, 32'h0, 8'h80);
    chk_out("sim_T1", 1, 1, 32'h341, 32'h200, 32'h0,   0, 32'h0);
    drive(NOP,   32'h204, 1'b0, 32'h0, 8'h80);
    chk_out("sim_T2", 1, 1, 32'h342, 32'd11,  32'h0,   0, 32'h0);
    drive(NOP,   32'h204, 1'b0, 32'h0, 8'h80);
    chk_out("sim_T3", 1, 0, 32'h0,   32'h0,   32'h305, 1, MTVEC);
    drive(NOP,   32'h300, 1'b0, 32'h0, 8'h80);
    chk_out("sim_T4", 1, 0, 32'h0,   32'h0,   32'h0,   0, 32'h0);
    drive(NOP,   32'h304, 1'b0, 32'h0, 8'h80);
    chk_out("sim_T5", 1, 1, 32'h341, 32'h300, 32'h0,   0, 32'h0);
    drive(NOP,   32'h304, 1'b0, 32'h0, 8'h00);
    chk_out("sim_T6", 1, 1, 32'h342, 32'h8000000B, 32'h0, 0, 32'h0);
    drive(NOP,   32'h304, 1'b0, 32'h0, 8'h00);
    chk_out("sim_T7", 1, 0, 32'h0,   32'h0,   32'h305, 1, MTVEC);
    drive(NOP,   32'h304, 1'b0, 32'h0, 8'h00);
    chk_out("sim_T8", 0, 0, 32'h0,   32'h0,   32'h0,   0, 32'h0);

    // reset during WR_MEPC of an ebreak aborts the sequence
    drive(EBREAK, 32'h500, 1'b0, 32'h0, 8'h00);
    chk_out("rstseq_T",  1, 0, 32'h0,   32'h0,   32'h0, 0, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1; inst_i = NOP; inst_addr_i = 32'h504;
    @(negedge clk);
    chk_out("rstseq_T1", 1, 1, 32'h341, 32'h500, 32'h0, 0, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_out("rstseq_T2", 0, 0, 32'h0,   32'h0,   32'h0, 0, 32'h0);
    drive(NOP, 32'h504, 1'b0, 32'h0, 8'h00);
    chk_out("rstseq_T3", 0, 0, 32'h0,   32'h0,   32'h0, 0, 32'h0);

    // fresh ecall after the abort runs normally
    drive(ECALL, 32'h600, 1'b0, 32'h0, 8'h00);
    chk_out("post_T",  1, 0, 32'h0,   32'h0,   32'h0,   0, 32'h0);
    drive(NOP,   32'h604, 1'b0, 32'h0, 8'h00);
    chk_out("post_T1", 1, 1, 32'h341, 32'h600, 32'h0,   0, 32'h0);
    drive(NOP,   32'h604, 1'b0, 32'h0, 8'h00);
    chk_out("post_T2", 1, 1, 32'h342, 32'd11,  32'h0,   0, 32'h0);
    drive(NOP,   32'h604, 1'b0, 32'h0, 8'h00);
    chk_out("post_T3", 1, 0, 32'h0,   32'h0,   32'h305, 1, MTVEC);
    drive(NOP,   32'h604, 1'b0, 32'h0, 8'h00);
    chk_out("post_T4", 0, 0, 32'h0,   32'h0,   32'h0,   0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
